// File: rtl/mole_spawner_if.sv
// Signal bundle between mole_spawner and its surroundings (board plus round control).
// The slave view is the spawner's side; the master view drives start and the board inputs.
interface mole_spawner_if;
    logic       start_i;
    logic [4:0] board_state_i;
    logic       score_trigger_i;
    logic       load_o;
    logic [4:0] loadval_o;
    logic       busy_o;
    logic       round_done_o;
    logic [7:0] spawn_count_o;

    modport slave (
        input  start_i, board_state_i, score_trigger_i,
        output load_o, loadval_o, busy_o, round_done_o, spawn_count_o
    );

    modport master (
        output start_i, board_state_i, score_trigger_i,
        input  load_o, loadval_o, busy_o, round_done_o, spawn_count_o
    );
endinterface

// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: paces spawns with a prescaled interval timer and picks a free hole from an LFSR.
// Define MOLE_SPEEDUP_EN to let hits shorten the spawn period; otherwise it stays at PERIOD_INIT.
module mole_spawner #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned PERIOD_INIT  = 1000,
    parameter int unsigned PERIOD_MIN   = 250,
    parameter int unsigned PERIOD_STEP  = 50,
    parameter int unsigned ROUND_SPAWNS = 30
) (
    input  logic           clk,
    input  logic           rst,
    mole_spawner_if.slave  bus
);

`ifdef MOLE_SPEEDUP_EN
    localparam bit SpeedupEn = 1'b1;
`else
    localparam bit SpeedupEn = 1'b0;
`endif

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 1) begin : g_badTickDiv
        $error("mole_spawner: TICK_DIV must be at least 1");
    end
    if (PERIOD_MIN < 1 || PERIOD_MIN > PERIOD_INIT || PERIOD_INIT > 65535) begin : g_badPeriod
        $error("mole_spawner: need 1 <= PERIOD_MIN <= PERIOD_INIT <= 65535");
    end
    if (ROUND_SPAWNS < 1 || ROUND_SPAWNS > 255) begin : g_badRound
        $error("mole_spawner: ROUND_SPAWNS must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SPAWN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [15:0]   interval_q, interval_d;
    logic [15:0]   period_q, period_d;
    logic [7:0]    spawnCount_q, spawnCount_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          scorePrev_q;

    logic          tick;
    logic          intervalReached;
    logic          lastSpawn;
    logic          hitEdge;
    logic          boardFull;
    logic [2:0]    baseIdx;
    logic [2:0]    freeIdx;
    logic          freeFound;
    logic [3:0]    cand;

    assign tick            = (state_q == WAIT) && (prescale_q == PW'(TICK_DIV - 1));
    assign intervalReached = ({1'b0, interval_q} + 17'd1) >= {1'b0, period_q};
    assign lastSpawn       = ({1'b0, spawnCount_q} + 9'd1) >= 9'(ROUND_SPAWNS);
    assign hitEdge         = bus.score_trigger_i & ~scorePrev_q;
    assign boardFull       = &bus.board_state_i;

    // Galois step with taps 16,14,13,11; free-running in every state.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);

    // Fold the LFSR's low bits onto 0..4, then walk upward with wrap to the first empty hole.
    always_comb begin
        baseIdx   = (lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0];
        freeIdx   = baseIdx;
        freeFound = 1'b0;
        cand      = 4'd0;
        for (int k = 0; k < 5; k++) begin
            cand = {1'b0, baseIdx} + 4'(k);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!freeFound && !bus.board_state_i[cand[2:0]]) begin
                freeFound = 1'b1;
                freeIdx   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        interval_d   = interval_q;
        period_d     = period_q;
        spawnCount_d = spawnCount_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d      = WAIT;
                    prescale_d   = '0;
                    interval_d   = '0;
                    spawnCount_d = '0;
                    period_d     = 16'(PERIOD_INIT);
                end
            end
            WAIT: begin
                if (tick) begin
                    prescale_d = '0;
                    interval_d = interval_q + 16'd1;
                    if (intervalReached) begin
                        state_d = SPAWN;
                    end
                end else begin
                    prescale_d = prescale_q + 1'b1;
                end
            end
            SPAWN: begin
                prescale_d   = '0;
                interval_d   = '0;
                spawnCount_d = spawnCount_q + 8'd1;
                state_d      = lastSpawn ? DONE : WAIT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturating decrement, compared in 32 bits so period - step cannot wrap.
        if (SpeedupEn && hitEdge && (state_q != IDLE)) begin
            if ({16'b0, period_q} < (PERIOD_MIN + PERIOD_STEP)) begin
                period_d = 16'(PERIOD_MIN);
            end else begin
                period_d = period_q - 16'(PERIOD_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            interval_q   <= '0;
            period_q     <= 16'(PERIOD_INIT);
            spawnCount_q <= '0;
            lfsr_q       <= 16'hACE1;
            scorePrev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            interval_q   <= interval_d;
            period_q     <= period_d;
            spawnCount_q <= spawnCount_d;
            lfsr_q       <= lfsr_d;
            scorePrev_q  <= bus.score_trigger_i;
        end
    end

    // A full board still counts as a spawn, it just never strobes load.
    assign bus.load_o        = (state_q == SPAWN) && !boardFull;
    assign bus.loadval_o     = bus.load_o ? (bus.board_state_i | (5'b00001 << freeIdx)) : 5'b00000;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.round_done_o  = (state_q == DONE);
    assign bus.spawn_count_o = spawnCount_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner with a load scoreboard driven by an LFSR/hole-search model.
// Build with MOLE_SPEEDUP_EN defined to exercise hit-driven period shortening.
module tb_mole_spawner;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic [15:0] mLfsr;

    typedef struct {
        int         cycleAt;
        logic [4:0] val;
    } expLoad_t;

    expLoad_t expQ[$];

    mole_spawner_if bus();

    mole_spawner #(
        .TICK_DIV    (4),
        .PERIOD_INIT (3),
        .PERIOD_MIN  (1),
        .PERIOD_STEP (1),
        .ROUND_SPAWNS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsrAhead(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsrStep(r);
        return r;
    endfunction

    function automatic logic [4:0] expectLoadval(input logic [15:0] v, input logic [4:0] board);
        int idx;
        int c;
        idx = int'(v[2:0]);
        if (idx >= 5) idx = idx - 5;
        for (int k = 0; k < 5; k++) begin
            c = (idx + k) % 5;
            if (!board[c]) return board | (5'b00001 << c);
        end
        return 5'b00000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) mLfsr <= 16'hACE1;
        else     mLfsr <= lfsrStep(mLfsr);
    end

    // Called at a falling edge: mLfsr and cyc then describe the current cycle.
    task automatic pushSpawn(input int cycleAt, input logic [4:0] board);
        expLoad_t e;
        e.cycleAt = cycleAt;
        e.val     = expectLoadval(lfsrAhead(mLfsr, cycleAt - cyc), board);
        if (board != 5'b11111) expQ.push_back(e);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle_timeout busy=%b required 0 within 200 cycles", name, bus.busy_o);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending_loads outstanding=%0d required 0", name, expQ.size());
        end
        expQ.delete();
    endtask

    // Scoreboard: every expected load must appear in its cycle, and no other loads may appear.
    always @(negedge clk) begin
        expLoad_t e;
        if (!rst) begin
            if (expQ.size() > 0 && expQ[0].cycleAt == cyc) begin
                e = expQ.pop_front();
                checks++;
                if (bus.load_o !== 1'b1 || bus.loadval_o !== e.val) begin
                    errors++;
                    $display("[TB] FAIL spawn_load cycle=%0d load=%b loadval=%b required load=1 loadval=%b",
                             cyc, bus.load_o, bus.loadval_o, e.val);
                end
            end else if (bus.load_o !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_load cycle=%0d load=%b loadval=%b required load=0",
                         cyc, bus.load_o, bus.loadval_o);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.load_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_load got=%b required 0", bus.load_o); end
        checks++;
        if (bus.loadval_o !== 5'b0) begin errors++; $display("[TB] FAIL reset_loadval got=%b required 00000", bus.loadval_o); end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b required 0", bus.busy_o); end
        checks++;
        if (bus.round_done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_round_done got=%b required 0", bus.round_done_o); end
        checks++;
        if (bus.spawn_count_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_spawn_count got=%0d required 0", bus.spawn_count_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_first_spawn();
        int c0;
        bus.board_state_i = 5'b00000;
        c0 = cyc;
        bus.start_i = 1'b1;
        for (int k = 1; k <= 4; k++) pushSpawn(c0 + 13 * k, 5'b00000);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 12);
        checks++;
        if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL first_busy got=%b required 1", bus.busy_o); end
        waitUntil(c0 + 14);
        checks++;
        if (bus.spawn_count_o !== 8'd1) begin errors++; $display("[TB] FAIL first_spawn_count got=%0d required 1", bus.spawn_count_o); end
        waitIdle("first_spawn");
    endtask

    task automatic test_full_round();
        int c0;
        bus.board_state_i = 5'b00101;
        repeat (2) @(negedge clk);
        c0 = cyc;
        bus.start_i = 1'b1;
        for (int k = 1; k <= 4; k++) pushSpawn(c0 + 13 * k, 5'b00101);
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            waitUntil(c0 + 13 * k + 1);
            checks++;
            if (bus.spawn_count_o !== 8'(k)) begin
                errors++;
                $display("[TB] FAIL round_spawn_count cycle=%0d got=%0d required %0d", cyc - c0, bus.spawn_count_o, k);
            end
        end
        waitUntil(c0 + 52);
        checks++;
        if (bus.round_done_o !== 1'b0) begin errors++; $display("[TB] FAIL round_done_early got=%b required 0", bus.round_done_o); end
        waitUntil(c0 + 53);
        checks++;
        if (bus.round_done_o !== 1'b1) begin errors++; $display("[TB] FAIL round_done_pulse got=%b required 1", bus.round_done_o); end
        checks++;
        if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL round_busy_done got=%b required 1", bus.busy_o); end
        checks++;
        if (bus.spawn_count_o !== 8'd4) begin errors++; $display("[TB] FAIL round_final_count got=%0d required 4", bus.spawn_count_o); end
        waitUntil(c0 + 54);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.round_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL round_end busy=%b round_done=%b required 0 0", bus.busy_o, bus.round_done_o);
        end
        waitIdle("full_round");
    endtask

    task automatic test_board_patterns();
        int c0;
        bus.board_state_i = 5'b01111;
        c0 = cyc;
        bus.start_i = 1'b1;
        pushSpawn(c0 + 13, 5'b01111);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 14);
        bus.board_state_i = 5'b11111;
        waitUntil(c0 + 26);
        checks++;
        if (bus.load_o !== 1'b0 || bus.loadval_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL full_board_load load=%b loadval=%b required 0 00000", bus.load_o, bus.loadval_o);
        end
        waitUntil(c0 + 27);
        checks++;
        if (bus.spawn_count_o !== 8'd2) begin errors++; $display("[TB] FAIL full_board_count got=%0d required 2", bus.spawn_count_o); end
        waitIdle("board_patterns");
        checks++;
        if (bus.spawn_count_o !== 8'd4) begin errors++; $display("[TB] FAIL full_board_final got=%0d required 4", bus.spawn_count_o); end
        bus.board_state_i = 5'b00000;
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        bus.board_state_i = 5'b10010;
        c0 = cyc;
        bus.start_i = 1'b1;
        for (int k = 1; k <= 4; k++) pushSpawn(c0 + 13 * k, 5'b10010);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 5);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 26);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        waitIdle("start_while_busy");
        c1 = cyc;
        bus.start_i = 1'b1;
        for (int k = 1; k <= 4; k++) pushSpawn(c1 + 13 * k, 5'b10010);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c1 + 2);
        checks++;
        if (bus.spawn_count_o !== 8'd0) begin errors++; $display("[TB] FAIL restart_count_clear got=%0d required 0", bus.spawn_count_o); end
        waitIdle("back_to_back");
        bus.board_state_i = 5'b00000;
    endtask

    task automatic test_speedup();
        int c0;
        int spacing;
        int first;
`ifdef MOLE_SPEEDUP_EN
        first   = 9;
        spacing = 5;
`else
        first   = 13;
        spacing = 13;
`endif
        bus.board_state_i = 5'b00000;
        c0 = cyc;
        bus.start_i = 1'b1;
        for (int k = 0; k < 4; k++) pushSpawn(c0 + first + spacing * k, 5'b00000);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 2);  bus.score_trigger_i = 1'b1;
        waitUntil(c0 + 3);  bus.score_trigger_i = 1'b0;
        waitUntil(c0 + 4);  bus.score_trigger_i = 1'b1;
        waitUntil(c0 + 5);  bus.score_trigger_i = 1'b0;
        waitUntil(c0 + 11); bus.score_trigger_i = 1'b1;
        waitUntil(c0 + 12); bus.score_trigger_i = 1'b0;
        waitUntil(c0 + first + spacing * 3 + 1);
        checks++;
        if (bus.round_done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL speedup_round_done cycle=%0d got=%b required 1", cyc - c0, bus.round_done_o);
        end
        waitIdle("speedup");
    endtask

    task automatic test_reset_mid_round();
        int c0;
        bus.board_state_i = 5'b00000;
        c0 = cyc;
        bus.start_i = 1'b1;
        for (int k = 1; k <= 4; k++) pushSpawn(c0 + 13 * k, 5'b00000);
        @(negedge clk);
        bus.start_i = 1'b0;
        waitUntil(c0 + 16);
        checks++;
        if (bus.spawn_count_o !== 8'd1) begin errors++; $display("[TB] FAIL midreset_pre_count got=%0d required 1", bus.spawn_count_o); end
        #2 rst = 1'b1;
        expQ.delete();
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.spawn_count_o !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async busy=%b spawn_count=%0d required 0 0", bus.busy_o, bus.spawn_count_o);
        end
        checks++;
        if (bus.load_o !== 1'b0 || bus.loadval_o !== 5'b0 || bus.round_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs load=%b loadval=%b round_done=%b required 0 00000 0",
                     bus.load_o, bus.loadval_o, bus.round_done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stays_idle busy=%b required 0", bus.busy_o); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout time=%0t required completion earlier", $time);
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        cyc                 = 0;
        checks              = 0;
        errors              = 0;
        bus.start_i         = 1'b0;
        bus.board_state_i   = 5'b00000;
        bus.score_trigger_i = 1'b0;
        test_reset();
        test_first_spawn();
        test_full_round();
        test_board_patterns();
        test_back_to_back();
        test_speedup();
        test_reset_mid_round();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
